// File: rtl/add48_seq_pkg.sv
// Shared constants and FSM encoding for the chunked sequential adder.
// Imported by the adder RTL and its bench.
package add48_seq_pkg;

  localparam int CHUNK_W    = 12;
  localparam int NCHUNK_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla12.sv
// 12-bit carry-look-ahead adder.
// Three 4-bit lookahead groups feed a second-level group carry unit.
module cla12 (
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic        carry_in,
  output logic [11:0] s,
  output logic        carry_out
);

  logic [11:0] g, p, c;
  logic [2:0]  gg, pg, gc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    pg = '0;
    for (int j = 0; j < 3; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      pg[j] = &p[4*j +: 4];
    end
  end

  // Group carries resolved in parallel from group g/p.
  assign gc[0] = carry_in;
  assign gc[1] = gg[0] | (pg[0] & carry_in);
  assign gc[2] = gg[1] | (pg[1] & gg[0])
               | (pg[1] & pg[0] & carry_in);
  assign carry_out = gg[2] | (pg[2] & gg[1])
                   | (pg[2] & pg[1] & gg[0])
                   | (pg[2] & pg[1] & pg[0] & carry_in);

  always_comb begin
    c = '0;
    for (int j = 0; j < 3; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1]
               | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2]
               | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
  end

  assign s = p ^ c;

endmodule

// File: rtl/add48_seq.sv
// Sequential wide adder: one shared 12-bit CLA processes
// one chunk per cycle, low chunk first.
module add48_seq
  import add48_seq_pkg::*;
#(
  parameter int NCHUNK = NCHUNK_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CHUNK_W*NCHUNK-1:0] a,
  input  logic [CHUNK_W*NCHUNK-1:0] b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [CHUNK_W*NCHUNK-1:0] sum,
  output logic                      cout
);

  localparam int W  = CHUNK_W * NCHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q;
  logic [W-1:0]        a_q, b_q, sum_q;
  logic                carry_q, cout_q;
  logic [CHUNK_W-1:0]  ca, cb, cs;
  logic                co;
  logic                last, accept;

  assign last   = (idx_q == IW'(NCHUNK - 1));
  assign accept = start && (state_q != RUN);

  assign ca = a_q[idx_q*CHUNK_W +: CHUNK_W];
  assign cb = b_q[idx_q*CHUNK_W +: CHUNK_W];

  cla12 u_cla (
    .a         (ca),
    .b         (cb),
    .carry_in  (carry_q),
    .s         (cs),
    .carry_out (co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
    end else if (state_q == RUN) begin
      sum_q[idx_q*CHUNK_W +: CHUNK_W] <= cs;
      carry_q <= co;
      idx_q   <= last ? '0 : idx_q + 1'b1;
      if (last) cout_q <= co;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
